// File: rtl/riscv_pkg.sv
// Shared types for the program-counter unit: FSM states and next-PC source selects.
package riscv_pkg;
   typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;
   typedef enum logic [2:0] {TRAP, MRET, BRANCH, HOLD, SEQ} pc_sel_e;
   localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/pc_unit_if.sv
// Control/redirect inputs and PC outputs of pc_unit; misaligned exists only with PC_MISALIGN_CHECK_EN.
interface pc_unit_if #(parameter int XLEN = 32);
   logic            stall;
   logic            halt_req;
   logic            resume;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            trap;
   logic            mret;
   logic [XLEN-1:0] epc;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus4;
   logic            pc_valid;
   logic            halted;
`ifdef PC_MISALIGN_CHECK_EN
   logic            misaligned;
`endif

   modport master (
      output stall, halt_req, resume, branch_taken, branch_target, trap, mret, epc,
      input  pc_out, pc_plus4, pc_valid, halted
`ifdef PC_MISALIGN_CHECK_EN
      , input misaligned
`endif
   );

   modport slave (
      input  stall, halt_req, resume, branch_taken, branch_target, trap, mret, epc,
      output pc_out, pc_plus4, pc_valid, halted
`ifdef PC_MISALIGN_CHECK_EN
      , output misaligned
`endif
   );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: trap > mret > branch > stall(hold) > sequential.
// Redirect targets are either word-aligned (default) or diverted to the trap vector (PC_MISALIGN_CHECK_EN).
module pc_next_mux
   import riscv_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100)
) (
   input  logic            trap,
   input  logic            mret,
   input  logic            branch_taken,
   input  logic            stall,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] epc,
   input  logic [XLEN-1:0] branch_target,
   output pc_sel_e         sel,
`ifdef PC_MISALIGN_CHECK_EN
   output logic            misalign,
`endif
   output logic [XLEN-1:0] next_pc
);
   logic [XLEN-1:0] target;
   logic            redirect;

   always_comb begin
      sel    = SEQ;
      target = pc_plus4;
      if (trap) begin
         sel    = TRAP;
         target = TRAP_VECTOR;
      end else if (mret) begin
         sel    = MRET;
         target = epc;
      end else if (branch_taken) begin
         sel    = BRANCH;
         target = branch_target;
      end else if (stall) begin
         sel    = HOLD;
         target = pc;
      end
   end

   assign redirect = (sel == MRET) || (sel == BRANCH);

`ifdef PC_MISALIGN_CHECK_EN
   assign misalign = redirect && (target[1:0] != 2'b00);
   assign next_pc  = misalign ? TRAP_VECTOR : target;
`else
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   assign next_pc = redirect ? (target & ALIGN_MASK) : target;
`endif
endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALTED control; redirects land one cycle after request.
// Optional PC_MISALIGN_CHECK_EN traps misaligned branch/mret targets and pulses misaligned.
module pc_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
   input logic     clk,
   input logic     rst,
   pc_unit_if.slave bus
);
   pc_state_e       state, state_nxt;
   pc_sel_e         sel;
   logic [XLEN-1:0] pc, pc_nxt, pc_inc, mux_pc;

   assign pc_inc = pc + XLEN'(PC_STEP);

`ifdef PC_MISALIGN_CHECK_EN
   logic mux_misalign, mis_q, mis_nxt;
`endif

   pc_next_mux #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR)) u_next_mux (
      .trap          (bus.trap),
      .mret          (bus.mret),
      .branch_taken  (bus.branch_taken),
      .stall         (bus.stall),
      .pc            (pc),
      .pc_plus4      (pc_inc),
      .epc           (bus.epc),
      .branch_target (bus.branch_target),
      .sel           (sel),
`ifdef PC_MISALIGN_CHECK_EN
      .misalign      (mux_misalign),
`endif
      .next_pc       (mux_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_VECTOR;
`ifdef PC_MISALIGN_CHECK_EN
         mis_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
`ifdef PC_MISALIGN_CHECK_EN
         mis_q <= mis_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
`ifdef PC_MISALIGN_CHECK_EN
      mis_nxt   = 1'b0;
`endif
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            pc_nxt = mux_pc;
`ifdef PC_MISALIGN_CHECK_EN
            mis_nxt = mux_misalign;
`endif
            // A halt still honours a same-cycle mret/branch, but never advances sequentially.
            if (bus.halt_req && !bus.trap) begin
               state_nxt = HALTED;
               if ((sel == HOLD) || (sel == SEQ)) pc_nxt = pc;
            end
         end
         HALTED: begin
            if (bus.trap) begin
               pc_nxt    = TRAP_VECTOR;
               state_nxt = RUN;
            end else if (bus.resume) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   assign bus.pc_out   = pc;
   assign bus.pc_plus4 = pc_inc;
   assign bus.pc_valid = (state == RUN);
   assign bus.halted   = (state == HALTED);
`ifdef PC_MISALIGN_CHECK_EN
   assign bus.misaligned = mis_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized bench for pc_unit against a rule-level reference model.
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pc_unit_if #(.XLEN(32)) bus ();

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: current PC plus "still booting" / "halted" flags.
   logic [31:0] m_pc;
   bit          m_boot, m_halt, m_mis;

   task automatic model_step();
      logic [31:0] tgt;
      bit          redir;
      tgt   = '0;
      redir = 0;
      if (rst) begin
         m_pc = 32'h0; m_boot = 1; m_halt = 0; m_mis = 0;
         return;
      end
      m_mis = 0;
      if (m_boot) begin
         m_boot = 0;
      end else if (m_halt) begin
         if (bus.trap) begin
            m_pc = 32'h100; m_halt = 0;
         end else if (bus.resume) begin
            m_halt = 0;
         end
      end else if (bus.trap) begin
         m_pc = 32'h100;
      end else begin
         if (bus.mret) begin
            tgt = bus.epc; redir = 1;
         end else if (bus.branch_taken) begin
            tgt = bus.branch_target; redir = 1;
         end
         if (redir) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (tgt % 4 != 0) begin
               m_pc = 32'h100; m_mis = 1;
            end else begin
               m_pc = tgt;
            end
`else
            m_pc = tgt - (tgt % 4);
`endif
         end else if (!(bus.halt_req || bus.stall)) begin
            m_pc = m_pc + 32'd4;
         end
         if (bus.halt_req) m_halt = 1;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".pc_out"},   bus.pc_out, m_pc);
      chk({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
      chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(!m_boot && !m_halt));
      chk({tag, ".halted"},   32'(bus.halted), 32'(m_halt));
`ifdef PC_MISALIGN_CHECK_EN
      chk({tag, ".misaligned"}, 32'(bus.misaligned), 32'(m_mis));
`endif
   endtask

   task automatic cycle(string tag);
      @(posedge clk);
      #1;
      model_step();
      check_all(tag);
   endtask

   task automatic clr();
      rst = 1'b0;
      bus.stall = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
      bus.branch_taken = 1'b0; bus.branch_target = '0;
      bus.trap = 1'b0; bus.mret = 1'b0; bus.epc = '0;
   endtask

   task automatic goto(logic [31:0] addr);
      clr();
      bus.branch_taken = 1'b1; bus.branch_target = addr;
      cycle("goto");
      clr();
   endtask

   initial begin
      clr();
      rst = 1'b1;
      cycle("reset");
      chk("reset.lit_pc", bus.pc_out, 32'h0);
      chk("reset.lit_valid", 32'(bus.pc_valid), 32'd0);
      rst = 1'b0;
      cycle("boot");
      chk("boot.lit_valid", 32'(bus.pc_valid), 32'd1);
      cycle("seq4");
      chk("seq4.lit_pc", bus.pc_out, 32'h4);
      cycle("seq8");
      chk("seq8.lit_pc", bus.pc_out, 32'h8);

      goto(32'h10);
      bus.stall = 1'b1;
      cycle("stall");
      chk("stall.lit_pc", bus.pc_out, 32'h10);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
      cycle("stall_branch");
      chk("stall_branch.lit_pc", bus.pc_out, 32'h200);

      goto(32'h20);
      bus.trap = 1'b1; bus.mret = 1'b1; bus.branch_taken = 1'b1;
      bus.epc = 32'h40; bus.branch_target = 32'h80;
      cycle("priority");
      chk("priority.lit_pc", bus.pc_out, 32'h100);
      clr();
      bus.mret = 1'b1; bus.epc = 32'h40; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
      cycle("mret_over_branch");

      goto(32'h30);
      bus.halt_req = 1'b1;
      cycle("halt");
      chk("halt.lit_halted", 32'(bus.halted), 32'd1);
      chk("halt.lit_pc", bus.pc_out, 32'h30);
      clr();
      bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
      bus.mret = 1'b1; bus.epc = 32'h600;
      cycle("halted_ignore");
      clr();
      bus.resume = 1'b1;
      cycle("resume");
      clr();
      cycle("after_resume");
      chk("after_resume.lit_pc", bus.pc_out, 32'h34);
      bus.halt_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h70;
      cycle("halt_with_branch");
      clr();
      bus.trap = 1'b1;
      cycle("halted_trap");
      chk("halted_trap.lit_pc", bus.pc_out, 32'h100);

      goto(32'hFFFF_FFFC);
      chk("wrap.lit_plus4", bus.pc_plus4, 32'h0);
      cycle("wrap");
      chk("wrap.lit_pc", bus.pc_out, 32'h0);

      bus.branch_taken = 1'b1; bus.branch_target = 32'h202;
      cycle("misalign_branch");
`ifdef PC_MISALIGN_CHECK_EN
      chk("misalign_branch.lit_pc", bus.pc_out, 32'h100);
      chk("misalign_branch.lit_flag", 32'(bus.misaligned), 32'd1);
`else
      chk("misalign_branch.lit_pc", bus.pc_out, 32'h200);
`endif
      clr();
      cycle("misalign_clear");
      bus.mret = 1'b1; bus.epc = 32'h43;
      cycle("misalign_mret");
      clr();

      bus.halt_req = 1'b1;
      cycle("halt2");
      clr();
      rst = 1'b1; bus.trap = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
      cycle("rst_in_halt");
      chk("rst_in_halt.lit_pc", bus.pc_out, 32'h0);
      clr();
      cycle("reboot");

      for (int i = 0; i < 400; i++) begin
         rst              = ($urandom_range(0, 49) == 0);
         bus.stall        = ($urandom_range(0, 3) == 0);
         bus.halt_req     = ($urandom_range(0, 11) == 0);
         bus.resume       = ($urandom_range(0, 2) == 0);
         bus.branch_taken = ($urandom_range(0, 4) == 0);
         bus.trap         = ($urandom_range(0, 15) == 0);
         bus.mret         = ($urandom_range(0, 9) == 0);
         bus.branch_target = $urandom();
         bus.epc           = $urandom();
         if ($urandom_range(0, 1) == 0) bus.branch_target[1:0] = 2'b00;
         cycle("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
